fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
Four-digit multiplexed 7-segment (FND) driver. It consumes the square-wave scan clock from the FND clock divider (about 1 kHz, generated in the i_clk domain) as a sampled signal, not as a clock. It converts a binary value to BCD and scans one digit per scan-clock rising edge, with anti-ghosting blanking between digits. It sits between the fan-controller datapath (speed/mode value) and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits; fixed at 4 for this revision.
BLANK_CYCLES, 100, i_clk cycles during which all digits are off after each digit change; 0 disables blanking.
VALUE_W, 14, width of i_value.

Ports:
i_clk  in  1  system clock (100 MHz)
i_reset  in  1  asynchronous, active-high reset
i_scan_clk  in  1  divider output, synchronous to i_clk; each rising edge advances the scan by one digit
i_value  in  VALUE_W  unsigned binary value to display; values above 9999 clamp to 9999
i_dp  in  4  decimal-point enables; bit k belongs to digit k
i_lz_blank  in  1  1 = suppress leading zeros
o_fnd_com  out  4  digit enables, active-low; bit k = digit k; digit 0 = rightmost (LSD)
o_fnd_font  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
o_digit_idx  out  2  index of the digit currently selected

Behaviour:
- Reset (async): o_fnd_com=4'b1111, o_fnd_font=8'hFF, o_digit_idx=0, displayed BCD=0000, dp shadow=0, converter idle, state=S_BLANK with count=BLANK_CYCLES.
- Tick: r_scan_d registers i_scan_clk, and tick = i_scan_clk & ~r_scan_d. A falling edge or a held level produces no tick.
- FSM S_BLANK / S_SHOW:
  - On a tick in either state, idx advances (NUM_DIGITS-1 wraps to 0) and the FSM enters S_BLANK with count=BLANK_CYCLES.
  - In S_BLANK, o_fnd_com=1111 and o_fnd_font=FF. The count decrements each cycle, and the FSM enters S_SHOW when it reaches 0.
  - With BLANK_CYCLES=0, the FSM goes straight to S_SHOW on the cycle after the tick.
  - A tick arriving during S_BLANK restarts the blank for the new idx.
- S_SHOW: o_fnd_com = ~(1<<idx), and o_fnd_font = font(digit[idx]) with bit7 = ~dp[idx]. All outputs are registered, so they reflect the state one cycle late.
- Frame capture: on the tick that wraps idx to 0, capture min(i_value, 9999) and i_dp, then start the converter.
- Converter: 14-iteration sequential double-dabble with a start/busy/done handshake. done fires 15 cycles after start. On done, the 16-bit BCD result and the captured dp are committed to the display registers in the same cycle.
  - When BLANK_CYCLES ≥ 16, a new frame's digit 0 always shows the new value.
  - A start while busy is ignored; the next wrap recaptures.
- Leading-zero suppression: digit k (k>0) is blank when i_lz_blank=1 and digits k..3 are all 0. Digit 0 is never suppressed. A suppressed digit outputs font {~dp[k],7'h7F}.
- Font (active-low, dp off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90. Non-BCD input gives FF.
- Reset mid-operation: all outputs return to reset values immediately, and an in-flight conversion is discarded.
- Tick spacing must be ≥ 17 i_clk cycles; with the divider it is 100 000.

Decomposition:
- Package fnd_pkg holds: the FONT_0..FONT_9 and FONT_BLANK constants, NUM_DIGITS, the BCD_MAX=9999 constant, and the state enum {S_BLANK, S_SHOW}.
- One sub-module: fnd_bin2bcd. Ports: i_clk, i_reset, i_start, i_bin[13:0], o_busy, o_done, o_bcd[15:0]. It is the sequential double-dabble converter.

Test Plan:
1. Fast-tick bench (i_scan_clk period 400 cycles), i_value=1234, i_lz_blank=0, after the first wrap plus 15 cycles -> com 1110 / font 99, com 1101 / B0, com 1011 / A4, com 0111 / F9.
2. i_value=7 with i_lz_blank=1 -> digits 3..1 font FF, digit0 F8. Then i_value=0 -> digit0 C0, others FF. Then i_lz_blank=0 -> all C0.
3. i_value=12000 -> every digit font 90 (clamped to 9999). i_value=9999 gives the same result.
4. i_value=1234, i_dp=4'b0100 -> digit2 font 24, all other fonts unchanged. i_dp changed mid-frame has no effect until the next wrap.
5. BLANK_CYCLES=100, one tick -> o_fnd_com=1111 for exactly 100 cycles, then the next digit is enabled. Holding i_scan_clk high or applying a falling edge gives no advance. A second tick during blank restarts the 100-cycle count.
6. Assert i_reset during S_SHOW mid-conversion -> same-cycle com=1111, font=FF, idx=0. After release with i_value=56, the first frame shows 0 and the next wrap shows 56.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants, font table and scan FSM states for the four-digit FND driver.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}, decimal point off
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  function automatic logic [7:0] bcd_font(input logic [3:0] digit);
    case (digit)
      4'd0:    bcd_font = FONT_0;
      4'd1:    bcd_font = FONT_1;
      4'd2:    bcd_font = FONT_2;
      4'd3:    bcd_font = FONT_3;
      4'd4:    bcd_font = FONT_4;
      4'd5:    bcd_font = FONT_5;
      4'd6:    bcd_font = FONT_6;
      4'd7:    bcd_font = FONT_7;
      4'd8:    bcd_font = FONT_8;
      4'd9:    bcd_font = FONT_9;
      default: bcd_font = FONT_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential double-dabble: 14 shift/add-3 iterations, done pulses 15 cycles after start.
module fnd_bin2bcd
  import fnd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [13:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_bcd
);

  logic [29:0] shift_reg;
  logic [3:0]  iter_reg;
  logic [15:0] adj;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (shift_reg[14 + gi*4 +: 4] >= 4'd5)
                            ? shift_reg[14 + gi*4 +: 4] + 4'd3
                            : shift_reg[14 + gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_reg <= '0;
      iter_reg  <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (o_busy) begin
        shift_reg <= {adj[14:0], shift_reg[13:0], 1'b0};
        iter_reg  <= iter_reg + 4'd1;
        if (iter_reg == 4'd13) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end else if (i_start) begin
        shift_reg <= {16'd0, i_bin};
        iter_reg  <= '0;
        o_busy    <= 1'b1;
      end
    end
  end

  // Result stays valid in the upper bits until the next start
  assign o_bcd = shift_reg[29:14];

endmodule

// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed 7-segment driver: scan-clock edge detect, blanking FSM,
// frame capture into a BCD converter, leading-zero suppression and registered pin outputs.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int BLANK_CYCLES = 100,
  parameter int VALUE_W      = 14
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_scan_clk,
  input  logic [VALUE_W-1:0] i_value,
  input  logic [3:0]         i_dp,
  input  logic               i_lz_blank,
  output logic [3:0]         o_fnd_com,
  output logic [7:0]         o_fnd_font,
  output logic [1:0]         o_digit_idx
);

  localparam int CNT_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  logic             scan_d_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [1:0]       idx_reg;
  logic [3:0]       cap_dp_reg;
  logic [15:0]      disp_bcd_reg;
  logic [3:0]       disp_dp_reg;

  logic        tick;
  logic        wrap_tick;
  logic [13:0] bin_clamped;
  logic        conv_busy;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic [3:0]  lz_sup;
  logic [3:0]  cur_digit;
  logic [7:0]  digit_font;
  logic [7:0]  font_next;

  assign tick        = i_scan_clk & ~scan_d_reg;
  assign wrap_tick   = tick && (idx_reg == 2'(NUM_DIGITS - 1));
  assign bin_clamped = (i_value > VALUE_W'(BCD_MAX)) ? 14'(BCD_MAX) : 14'(i_value);

  fnd_bin2bcd u_bin2bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (wrap_tick),
    .i_bin   (bin_clamped),
    .o_busy  (conv_busy),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  // A digit is a leading zero when it and every more significant digit are zero
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_sup[gi] = 1'b0;
      end else begin : g_upper
        assign lz_sup[gi] = i_lz_blank && (disp_bcd_reg[15:gi*4] == '0);
      end
    end
  endgenerate

  assign cur_digit = disp_bcd_reg[{idx_reg, 2'b00} +: 4];

  always_comb begin
    digit_font = bcd_font(cur_digit);
    font_next  = {~disp_dp_reg[idx_reg], digit_font[6:0]};
    if (lz_sup[idx_reg]) begin
      font_next = {~disp_dp_reg[idx_reg], 7'h7F};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scan_d_reg   <= 1'b0;
      state_reg    <= S_BLANK;
      count_reg    <= BLANK_LOAD;
      idx_reg      <= '0;
      cap_dp_reg   <= '0;
      disp_bcd_reg <= '0;
      disp_dp_reg  <= '0;
      o_fnd_com    <= 4'hF;
      o_fnd_font   <= FONT_BLANK;
      o_digit_idx  <= '0;
    end else begin
      scan_d_reg <= i_scan_clk;

      if (tick) begin
        idx_reg   <= idx_reg + 2'd1;
        state_reg <= S_BLANK;
        count_reg <= BLANK_LOAD;
      end else if (state_reg == S_BLANK) begin
        if (count_reg <= CNT_W'(1)) begin
          state_reg <= S_SHOW;
        end else begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end

      // dp is only captured when the converter accepts the frame, keeping the pair consistent
      if (wrap_tick && !conv_busy) begin
        cap_dp_reg <= i_dp;
      end
      if (conv_done) begin
        disp_bcd_reg <= conv_bcd;
        disp_dp_reg  <= cap_dp_reg;
      end

      if (state_reg == S_SHOW) begin
        o_fnd_com  <= ~(4'b0001 << idx_reg);
        o_fnd_font <= font_next;
      end else begin
        o_fnd_com  <= 4'hF;
        o_fnd_font <= FONT_BLANK;
      end
      o_digit_idx <= idx_reg;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: expected digits queued per frame, popped as each digit shows.
module tb_fnd_scan_driver;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
    logic [1:0] idx;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_scan_clk;
  logic [13:0] i_value;
  logic [3:0]  i_dp;
  logic        i_lz_blank;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_font;
  logic [1:0]  o_digit_idx;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  fnd_scan_driver #(
    .BLANK_CYCLES (100),
    .VALUE_W      (14)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_scan_clk  (i_scan_clk),
    .i_value     (i_value),
    .i_dp        (i_dp),
    .i_lz_blank  (i_lz_blank),
    .o_fnd_com   (o_fnd_com),
    .o_fnd_font  (o_fnd_font),
    .o_digit_idx (o_digit_idx)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_font(input int value, input logic [3:0] dp,
                                            input logic lz, input int k);
    int v, p, d;
    logic [7:0] f;
    v = (value > 9999) ? 9999 : value;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    d = (v / p) % 10;
    f = font_tbl[d];
    if (lz && k > 0 && v < p) f = 8'hFF;
    return {~dp[k], f[6:0]};
  endfunction

  task automatic push_frame(input int value, input logic [3:0] dp, input logic lz);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.com  = ~(4'b0001 << k);
      e.font = model_font(value, dp, lz, k);
      e.idx  = 2'(k);
      sb.push_back(e);
    end
  endtask

  // Wait for the blank period after a tick to end and a digit to be lit
  task automatic wait_show();
    int n;
    n = 0;
    repeat (2) @(negedge i_clk);
    while (o_fnd_com === 4'hF && n < 300) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $error("FAIL show_timeout observed=blank expected=digit lit");
    end
  endtask

  task automatic do_tick();
    @(negedge i_clk);
    i_scan_clk = 1'b1;
    wait_show();
    repeat (20) @(negedge i_clk);
    i_scan_clk = 1'b0;
    repeat (20) @(negedge i_clk);
  endtask

  task automatic check_digit();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=queued digit");
      return;
    end
    e = sb.pop_front();
    $display("digit %0d com=%b font=%h (exp com=%b font=%h)", e.idx, o_fnd_com, o_fnd_font, e.com, e.font);
    check($sformatf("com_d%0d", e.idx), 32'(o_fnd_com), 32'(e.com));
    check($sformatf("font_d%0d", e.idx), 32'(o_fnd_font), 32'(e.font));
    check($sformatf("idx_d%0d", e.idx), 32'(o_digit_idx), 32'(e.idx));
  endtask

  // Tick until the scan wraps to digit 0 (capturing the inputs), then check all four digits
  task automatic frame(input int value, input logic [3:0] dp, input logic lz, input logic [3:0] dp_after);
    int guard;
    i_value    = 14'(value);
    i_dp       = dp;
    i_lz_blank = lz;
    push_frame(value, dp, lz);
    guard = 0;
    do begin
      do_tick();
      guard++;
    end while (o_digit_idx !== 2'd0 && guard < 5);
    check_digit();
    i_dp = dp_after;
    for (int k = 1; k < 4; k++) begin
      do_tick();
      check_digit();
    end
  endtask

  task automatic count_blank(output int n);
    n = 0;
    repeat (2) @(negedge i_clk);
    while (o_fnd_com === 4'hF && n < 400) begin
      n++;
      @(negedge i_clk);
    end
  endtask

  initial begin
    int n;
    i_reset    = 1'b1;
    i_scan_clk = 1'b0;
    i_value    = '0;
    i_dp       = '0;
    i_lz_blank = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_com", 32'(o_fnd_com), 32'h0000000F);
    check("reset_font", 32'(o_fnd_font), 32'h000000FF);
    check("reset_idx", 32'(o_digit_idx), 32'h0);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);

    // Basic value, leading-zero suppression, clamping
    frame(1234, 4'b0000, 1'b0, 4'b0000);
    frame(7,    4'b0000, 1'b1, 4'b0000);
    frame(0,    4'b0000, 1'b1, 4'b0000);
    frame(0,    4'b0000, 1'b0, 4'b0000);
    frame(12000, 4'b0000, 1'b0, 4'b0000);
    frame(9999, 4'b0000, 1'b0, 4'b0000);
    // dp on digit 2; clearing it mid-frame must not affect this frame
    frame(1234, 4'b0100, 1'b0, 4'b0000);
    frame(1234, 4'b0000, 1'b0, 4'b0000);

    // Blank length, held level, falling edge, restart during blank
    @(negedge i_clk);
    i_scan_clk = 1'b1;
    count_blank(n);
    check("blank_len", 32'(n), 32'd100);
    check("blank_next_com", 32'(o_fnd_com), 32'h0000000E);
    check("blank_next_idx", 32'(o_digit_idx), 32'h0);
    repeat (200) @(negedge i_clk);
    check("held_high_idx", 32'(o_digit_idx), 32'h0);
    check("held_high_com", 32'(o_fnd_com), 32'h0000000E);
    i_scan_clk = 1'b0;
    repeat (50) @(negedge i_clk);
    check("fall_idx", 32'(o_digit_idx), 32'h0);
    check("fall_com", 32'(o_fnd_com), 32'h0000000E);
    i_scan_clk = 1'b1;
    repeat (30) @(negedge i_clk);
    i_scan_clk = 1'b0;
    repeat (10) @(negedge i_clk);
    i_scan_clk = 1'b1;
    count_blank(n);
    check("restart_blank_len", 32'(n), 32'd100);
    check("restart_com", 32'(o_fnd_com), 32'h0000000B);
    check("restart_idx", 32'(o_digit_idx), 32'h2);
    i_scan_clk = 1'b0;
    repeat (20) @(negedge i_clk);

    // Asynchronous reset while a digit is lit
    frame(1234, 4'b0000, 1'b0, 4'b0000);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("async_reset_com", 32'(o_fnd_com), 32'h0000000F);
    check("async_reset_font", 32'(o_fnd_font), 32'h000000FF);
    check("async_reset_idx", 32'(o_digit_idx), 32'h0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    // Reset during an in-flight conversion: the captured value must be discarded
    i_value = 14'd4321;
    for (int k = 0; k < 3; k++) do_tick();
    @(negedge i_clk);
    i_scan_clk = 1'b1;
    repeat (5) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_scan_clk = 1'b0;
    i_value    = 14'd56;
    i_reset    = 1'b0;
    push_frame(0, 4'b0000, 1'b0);
    wait_show();
    check_digit();
    for (int k = 1; k < 4; k++) begin
      do_tick();
      check_digit();
    end
    frame(56, 4'b0000, 1'b0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
